// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper and seven-segment driver:
// BCD digit type, active-low segment patterns, anode selects and BCD increment.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Segment patterns in {g,f,e,d,c,b,a} order, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    // Adds one to a packed 4-digit BCD value; callers guard against SCORE_MAX.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder; values above 9
// decode to a blank digit.
import score_pkg::*;

module seg7_decode (
    input  bcd_digit_t digit_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_seg_driver.sv
// Game score keeper (saturating packed BCD) and 4-digit multiplexed display driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
import score_pkg::*;

module score_seg_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        status,
    output logic [15:0] score_bcd,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      score_q, score_d;
    logic             status_q;
    logic [CNT_W-1:0] div_q, div_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    bcd_digit_t       cur_digit;
    logic [6:0]       cur_seg;
    logic [3:0]       digit_blank;
    logic             status_rise;

    assign status_rise = status & ~status_q;

    // A new game clears the score even when a tick lands in the same cycle
    always_comb begin
        score_d = score_q;
        if (status_rise) begin
            score_d = 16'h0000;
        end else if (status && tick_1hz && (score_q != SCORE_MAX)) begin
            score_d = bcd_inc(score_q);
        end
    end

    always_comb begin
        div_d = div_q + CNT_W'(1);
        dig_d = dig_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            dig_d = dig_q + 2'd1;
        end
    end

    assign digit_blank[0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
        assign digit_blank[gi] = (score_q[15:gi*4] == '0);
    end
`else
    for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
        assign digit_blank[gi] = 1'b0;
    end
`endif

    assign cur_digit = score_q[{dig_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .digit_i (cur_digit),
        .seg_n_o (cur_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!digit_blank[dig_q]) begin
            seg_d = cur_seg;
            case (dig_q)
                2'd0:    an_d = AN_DIG0;
                2'd1:    an_d = AN_DIG1;
                2'd2:    an_d = AN_DIG2;
                default: an_d = AN_DIG3;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            score_q  <= 16'h0000;
            status_q <= 1'b0;
            div_q    <= '0;
            dig_q    <= 2'd0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
        end else begin
            score_q  <= score_d;
            status_q <= status;
            div_q    <= div_d;
            dig_q    <= dig_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign score_bcd = score_q;
    assign an_n      = an_q;
    assign seg_n     = seg_q;

endmodule

// File: tb/tb_score_seg_driver.sv
// Self-checking bench for score_seg_driver with a short refresh divider; honours
// LEADING_ZERO_BLANK_EN when computing expected display values.
`timescale 1ns/1ps

module tb_score_seg_driver;

    localparam int DIV = 4;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        tick_1hz;
    logic        status;
    logic [15:0] score_bcd;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;

    int n_vec = 0;
    int n_err = 0;

    score_seg_driver #(.REFRESH_DIV(DIV)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .status     (status),
        .score_bcd  (score_bcd),
        .an_n       (an_n),
        .seg_n      (seg_n)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int          ticks;
        logic        status;
        logic [15:0] exp_score;
        logic [6:0]  exp_seg1;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One tick pulse per two clocks; returns on the negedge after it was sampled.
    task automatic apply_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick_1hz = 1'b1;
            @(negedge clk_100MHz);
            tick_1hz = 1'b0;
            @(negedge clk_100MHz);
        end
    endtask

    // Waits (bounded) for a given anode pattern and checks the segments shown there.
    task automatic check_slot(input string name, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        logic found;
        found = 1'b0;
        for (int g = 0; g < 6 * DIV && !found; g++) begin
            @(negedge clk_100MHz);
            if (an_n == an_exp) found = 1'b1;
        end
        check({name, "_found"}, {15'd0, found}, 16'd1);
        if (found) check(name, {9'd0, seg_n}, {9'd0, seg_exp});
    endtask

    vec_t vecs[6];

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev_an;
    logic       synced;

    initial begin
        vecs[0] = '{123,  1'b1, 16'h0123, 7'b0100100};
        vecs[1] = '{876,  1'b1, 16'h0999, 7'b0010000};
        vecs[2] = '{1,    1'b1, 16'h1000, 7'b1000000};
        vecs[3] = '{8999, 1'b1, 16'h9999, 7'b0010000};
        vecs[4] = '{6,    1'b1, 16'h9999, 7'b0010000};
        vecs[5] = '{5,    1'b0, 16'h9999, 7'b0010000};

        reset    = 1'b1;
        tick_1hz = 1'b0;
        status   = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("rst_score", score_bcd, 16'h0000);
        check("rst_an", {12'd0, an_n}, 16'h000F);
        check("rst_seg", {9'd0, seg_n}, 16'h007F);
        reset = 1'b0;
        @(negedge clk_100MHz);
        check("first_an", {12'd0, an_n}, 16'h000E);
        check("first_seg", {9'd0, seg_n}, 16'h0040);

        for (int i = 0; i < 6; i++) begin
            status = vecs[i].status;
            @(negedge clk_100MHz);
            apply_ticks(vecs[i].ticks);
            check($sformatf("vec%0d_score", i), score_bcd, vecs[i].exp_score);
            check_slot($sformatf("vec%0d_dig1", i), 4'b1101, vecs[i].exp_seg1);
            $display("vec %0d: %0d ticks status=%0b -> score %h", i, vecs[i].ticks, vecs[i].status, score_bcd);
        end

        // New game without a tick, then count to 42 and freeze
        status = 1'b1;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        check("newgame_clear", score_bcd, 16'h0000);
        apply_ticks(42);
        check("count_42", score_bcd, 16'h0042);
        status = 1'b0;
        @(negedge clk_100MHz);
        apply_ticks(5);
        check("freeze_42", score_bcd, 16'h0042);

        // Rising status together with a tick: clear wins
        status   = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk_100MHz);
        tick_1hz = 1'b0;
        check("rise_tick_clear", score_bcd, 16'h0000);
        @(negedge clk_100MHz);
        apply_ticks(1);
        check("after_clear_tick", score_bcd, 16'h0001);
        apply_ticks(41);
        check("scan_score", score_bcd, 16'h0042);

        // Scan of 0x0042: check every cycle of a full frame
        exp_an[0] = 4'b1110; exp_seg[0] = 7'b0100100;
        exp_an[1] = 4'b1101; exp_seg[1] = 7'b0011001;
`ifdef LEADING_ZERO_BLANK_EN
        exp_an[2] = 4'b1111; exp_seg[2] = 7'b1111111;
        exp_an[3] = 4'b1111; exp_seg[3] = 7'b1111111;
`else
        exp_an[2] = 4'b1011; exp_seg[2] = 7'b1000000;
        exp_an[3] = 4'b0111; exp_seg[3] = 7'b1000000;
`endif
        prev_an = an_n;
        synced  = 1'b0;
        for (int g = 0; g < 6 * DIV && !synced; g++) begin
            @(negedge clk_100MHz);
            if (an_n == 4'b1110 && prev_an != 4'b1110) synced = 1'b1;
            prev_an = an_n;
        end
        check("scan_sync", {15'd0, synced}, 16'd1);
        for (int k = 0; k < 4 * DIV + 1; k++) begin
            check($sformatf("scan_an_c%0d", k), {12'd0, an_n}, {12'd0, exp_an[(k / DIV) % 4]});
            check($sformatf("scan_seg_c%0d", k), {9'd0, seg_n}, {9'd0, exp_seg[(k / DIV) % 4]});
            @(negedge clk_100MHz);
        end

        // Asynchronous reset mid-game: no clock edge between assert and check
        #2 reset = 1'b1;
        #1;
        check("async_rst_score", score_bcd, 16'h0000);
        check("async_rst_an", {12'd0, an_n}, 16'h000F);
        check("async_rst_seg", {9'd0, seg_n}, 16'h007F);
        @(negedge clk_100MHz);
        reset = 1'b0;
        @(negedge clk_100MHz);
        check("rerelease_an", {12'd0, an_n}, 16'h000E);
        check("rerelease_seg", {9'd0, seg_n}, 16'h0040);
        check("rerelease_score", score_bcd, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
